nonce_sweep_ctrl: RTL and testbench
===================================

# nonce_sweep_ctrl

Sequencing stage directly upstream of the two-phase SHA-256 hashing core. It takes a block-1 midstate and the three fixed tail words of a Bitcoin header, and launches the core once per nonce over a range. It collects each final hash and compares word 0 against a 32-bit target. It reports the winning nonce and its hash to the host-side register block.

## Interface

Parameters:
- `NUM_NONCES`, default 16: nonces tried per sweep, range 1..65535.

Ports:
- `clk` (in, 1): sole clock; all logic on its rising edge.
- `reset_n` (in, 1): reset, synchronous, active-low.
- `start` (in, 1): sweep request; sampled only in IDLE.
- `midstate[8]` (in, 32 each): forwarded unchanged to the core's initial hash input.
- `tail[3]` (in, 32 each): header words 16..18.
- `nonce_base` (in, 32): first nonce.
- `target` (in, 32): hit when `hash[0] < target`, unsigned.
- `core_start` (out, 1): one-cycle launch pulse to the core.
- `core_inh[8]` (out, 32 each): driven from latched midstate.
- `core_message[4]` (out, 32 each): {tail[0], tail[1], tail[2], current nonce}.
- `core_done` (in, 1): core level status; high while the core is idle.
- `core_outs[8]` (in, 32 each): core hash; valid on the cycle `core_done` rises.
- `busy` (out, 1): high from the accepted `start` until `done`.
- `done` (out, 1): one-cycle pulse at sweep end.
- `found` (out, 1): at least one hit in the last sweep; held until the next accepted `start`.
- `found_nonce` (out, 32): nonce of the reported hit.
- `found_hash[8]` (out, 32 each): hash of the reported hit.
- `tried` (out, 16): nonces completed in the current or last sweep.

## Operation

- States: IDLE, LAUNCH, WAIT_LO, WAIT_HI, CHECK, FINISH.
- **IDLE**
  - On `start`: latch `midstate`, `tail`, `target`; load nonce with `nonce_base`.
  - Clear `found`, `found_nonce`, `found_hash`, `tried`.
  - Set `busy`; go to LAUNCH.
- **LAUNCH**
  - If `core_done`=1: pulse `core_start` and go to WAIT_LO.
  - Otherwise stay in LAUNCH; the core is still busy from an earlier request.
- **WAIT_LO**: wait for `core_done`=0, the core acknowledging the launch. Go to WAIT_HI.
- **WAIT_HI**
  - Wait for `core_done`=1.
  - On that cycle, capture `core_outs` into a hash register; go to CHECK.
- **CHECK**
  - Hit = `hash[0] < target`.
  - Increment `tried`.
  - Nonce increments modulo 2^32; `32'hFFFFFFFF` wraps to 0 with no flag.
  - If `tried` (after increment) equals `NUM_NONCES`, or an early exit applies (see Configuration), go to FINISH. Otherwise go to LAUNCH.
- **FINISH**: pulse `done`; clear `busy`; go to IDLE.
- `core_inh` and `core_message` are driven from registers. They stay stable from LAUNCH through WAIT_HI.
- `start` outside IDLE is ignored. Latched inputs are immune to input changes mid-sweep.
- Reset mid-sweep:
  - Go to IDLE.
  - All outputs return to reset values next cycle.
  - `core_start` deasserts immediately on that edge.
  - A core run already in flight is not cancelled. The next sweep waits for it in LAUNCH.

## Timing

- Reset values:
  - `core_start`, `busy`, `done`, `found` = 0.
  - `found_nonce`, `found_hash`, `tried` = 0.
  - `core_inh`, `core_message` = 0.
- Sweep overhead per nonce: LAUNCH 1, WAIT_LO ≥1, WAIT_HI ≥1, CHECK 1, i.e. 4 cycles plus core latency. FINISH adds 1 cycle once per sweep.
- Latencies:
  - `start` to first `core_start`: 1 cycle (LAUNCH entered the cycle after `start`).
  - `core_done` rise to hash captured: same edge.
  - Captured to `found` update: 1 cycle (CHECK).
- `done` and `busy` falling occur on the same edge.
- `found_*` are stable whenever `done` is high.

## Configuration

- `NONCE_EARLY_EXIT_EN`
  - **Defined:** the first hit ends the sweep. CHECK goes to FINISH. `found_nonce` and `found_hash` are that hit; `tried` counts up to and including it.
  - **Undefined:** every sweep runs all `NUM_NONCES`. The reported hit is the one with the smallest `hash[0]`; ties keep the earliest nonce. `tried` always equals `NUM_NONCES` at `done`.

## Test plan

The bench uses a stub core with latency L=10. Its `core_outs[0]` = `32'hFFFF0000 ^ message[3]` and its other words = `message[3]`.

- **No hit:** `nonce_base`=0, `target`=1, `NUM_NONCES`=16 → 16 `core_start` pulses, `done` after 16·(4+L)+2 cycles, `found`=0, `tried`=16.
- **Single hit:** `nonce_base`=`32'hFFFF0000`, `target`=8 → nonce `FFFF0000` gives `hash[0]`=0 → `found`=1, `found_nonce`=`32'hFFFF0000`. Early-exit: `tried`=1. Otherwise: `tried`=16 and the same nonce is reported (smallest).
- **Wrap:** `nonce_base`=`32'hFFFFFFFE`, `NUM_NONCES`=4 → `core_message[3]` sequence FFFFFFFE, FFFFFFFF, 0, 1.
- **Busy core:** hold `core_done`=0 for 20 cycles after `start` → `core_start` stays 0 until `core_done` rises, then pulses exactly once.
- **Start during sweep:** second `start` pulse plus changed `tail` mid-sweep → ignored; `core_message[0..2]` unchanged; exactly one `done`.
- **Reset mid-sweep:** assert `reset_n`=0 in WAIT_HI → next cycle `busy`=0, `found`=0, `tried`=0, `core_start`=0. A new `start` after release completes normally.

Source files
------------

// File: rtl/nonce_sweep_ctrl_if.sv
// Launch/result handshake between the nonce sweep controller (master) and the
// two-phase SHA-256 core (slave).
interface nonce_sweep_ctrl_if;
  logic        core_start;
  logic [31:0] core_inh     [8];
  logic [31:0] core_message [4];
  logic        core_done;
  logic [31:0] core_outs    [8];

  modport master (output core_start, core_inh, core_message,
                  input  core_done, core_outs);
  modport slave  (input  core_start, core_inh, core_message,
                  output core_done, core_outs);
endinterface

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps NUM_NONCES nonces through the SHA-256 core and reports the best hit
// against a 32-bit target. Define NONCE_EARLY_EXIT_EN to stop at the first hit.
module nonce_sweep_ctrl #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] midstate [8],
  input  logic [31:0] tail     [3],
  input  logic [31:0] nonce_base,
  input  logic [31:0] target,
  nonce_sweep_ctrl_if.master core,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic [31:0] found_hash [8],
  output logic [15:0] tried
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_LO, WAIT_HI, CHECK, FINISH} state_e;

  localparam logic [15:0] NumLast = 16'(NUM_NONCES);

  state_e      state_q, state_d;
  logic [31:0] midstate_q [8], midstate_d [8];
  logic [31:0] tail_q [3], tail_d [3];
  logic [31:0] target_q, target_d;
  logic [31:0] nonce_q, nonce_d;
  logic [31:0] hash_q [8], hash_d [8];
  logic        found_q, found_d;
  logic [31:0] found_nonce_q, found_nonce_d;
  logic [31:0] found_hash_q [8], found_hash_d [8];
  logic [15:0] tried_q, tried_d;

  logic is_hit, take_hit, last;

  assign is_hit = hash_q[0] < target_q;

`ifdef NONCE_EARLY_EXIT_EN
  assign take_hit = is_hit;
  assign last     = ((tried_q + 16'd1) == NumLast) || is_hit;
`else
  // Strict compare keeps the earliest nonce when two hashes tie.
  assign take_hit = is_hit && (!found_q || (hash_q[0] < found_hash_q[0]));
  assign last     = (tried_q + 16'd1) == NumLast;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the arrays are reset because they feed core_inh/found_hash directly,
  // which must read zero out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      midstate_q    <= '{default: '0};
      tail_q        <= '{default: '0};
      target_q      <= '0;
      nonce_q       <= '0;
      hash_q        <= '{default: '0};
      found_q       <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '{default: '0};
      tried_q       <= '0;
    end else begin
      state_q       <= state_d;
      midstate_q    <= midstate_d;
      tail_q        <= tail_d;
      target_q      <= target_d;
      nonce_q       <= nonce_d;
      hash_q        <= hash_d;
      found_q       <= found_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      tried_q       <= tried_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LAUNCH;
      LAUNCH:  if (core.core_done) state_d = WAIT_LO;
      WAIT_LO: if (!core.core_done) state_d = WAIT_HI;
      WAIT_HI: if (core.core_done) state_d = CHECK;
      CHECK:   state_d = last ? FINISH : LAUNCH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every _d starts from its _q so no path leaves a latch behind.
  always_comb begin
    midstate_d    = midstate_q;
    tail_d        = tail_q;
    target_d      = target_q;
    nonce_d       = nonce_q;
    hash_d        = hash_q;
    found_d       = found_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    tried_d       = tried_q;
    case (state_q)
      IDLE: if (start) begin
        midstate_d    = midstate;
        tail_d        = tail;
        target_d      = target;
        nonce_d       = nonce_base;
        found_d       = 1'b0;
        found_nonce_d = '0;
        found_hash_d  = '{default: '0};
        tried_d       = '0;
      end
      WAIT_HI: if (core.core_done) hash_d = core.core_outs;
      CHECK: begin
        tried_d = tried_q + 16'd1;
        nonce_d = nonce_q + 32'd1;
        if (take_hit) begin
          found_d       = 1'b1;
          found_nonce_d = nonce_q;
          found_hash_d  = hash_q;
        end
      end
      default: ;
    endcase
  end

  // Strobes decode straight from state so a reset edge drops them at once.
  always_comb begin
    core.core_start   = (state_q == LAUNCH) && core.core_done;
    busy              = state_q != IDLE;
    done              = state_q == FINISH;
    core.core_inh     = midstate_q;
    core.core_message = '{tail_q[0], tail_q[1], tail_q[2], nonce_q};
  end

  assign found       = found_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign tried       = tried_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Self-checking bench for nonce_sweep_ctrl: stub core with latency L, randomized
// sweeps compared against a nonce-by-nonce reference model.
module tb_nonce_sweep_ctrl;
  localparam int NUM = 16;
  localparam int L   = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] midstate [8];
  logic [31:0] tail [3];
  logic [31:0] nonce_base = '0;
  logic [31:0] target = '0;
  logic        busy, done, found;
  logic [31:0] found_nonce;
  logic [31:0] found_hash [8];
  logic [15:0] tried;

  nonce_sweep_ctrl_if cif ();

  nonce_sweep_ctrl #(.NUM_NONCES(NUM)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .midstate(midstate), .tail(tail),
    .nonce_base(nonce_base), .target(target), .core(cif), .busy(busy), .done(done),
    .found(found), .found_nonce(found_nonce), .found_hash(found_hash), .tried(tried));

  always #5 clk = ~clk;

  // Stub core: idle high, drops after a launch, rises L+1 edges later with the hash.
  int          stub_cnt = 0;
  logic        stub_idle = 1'b1;
  logic        hold_busy = 1'b0;
  logic [31:0] stub_msg = '0;
  logic [31:0] stub_outs [8] = '{default: '0};
  assign cif.core_done = stub_idle && !hold_busy;
  assign cif.core_outs = stub_outs;

  always @(posedge clk) begin
    if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_idle    <= 1'b1;
        stub_outs[0] <= 32'hFFFF0000 ^ stub_msg;
        for (int i = 1; i < 8; i++) stub_outs[i] <= stub_msg;
      end
    end else if (cif.core_start) begin
      stub_cnt  <= L + 1;
      stub_idle <= 1'b0;
      stub_msg  <= cif.core_message[3];
    end
  end

  int total = 0, bad = 0;

  // Launch monitor
  logic [31:0] launches[$];
  logic [31:0] exp_mid [8];
  logic [31:0] exp_tail [3];
  int msg_bad, dbl_cnt, done_cnt;
  logic prev_cs = 1'b0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (cif.core_start) begin
        launches.push_back(cif.core_message[3]);
        for (int i = 0; i < 3; i++) if (cif.core_message[i] !== exp_tail[i]) msg_bad++;
        for (int i = 0; i < 8; i++) if (cif.core_inh[i] !== exp_mid[i]) msg_bad++;
        if (prev_cs) dbl_cnt++;
      end
      if (done) done_cnt++;
    end
    prev_cs = cif.core_start;
  end

  // Reference model: walk the nonces and apply the hit/report rules directly.
  logic        exp_found;
  logic [31:0] exp_nonce, exp_h0;
  int          exp_tried;

  task automatic model_sweep(input logic [31:0] base, input logic [31:0] tgt);
    logic [31:0] n, h0;
    exp_found = 1'b0; exp_nonce = '0; exp_h0 = '0; exp_tried = 0;
    for (int i = 0; i < NUM; i++) begin
      n = base + 32'(i);
      h0 = 32'hFFFF0000 ^ n;
      exp_tried = i + 1;
      if (h0 < tgt && (!exp_found || h0 < exp_h0)) begin
        exp_found = 1'b1; exp_nonce = n; exp_h0 = h0;
      end
`ifdef NONCE_EARLY_EXIT_EN
      if (exp_found) break;
`endif
    end
  endtask

  // Observed results of the last sweep
  logic        obs_found, obs_timeout;
  logic [31:0] obs_nonce, obs_h0, obs_h7;
  logic [15:0] obs_tried;
  int          obs_cycles, early_starts;

  task automatic do_sweep(input logic [31:0] base, input logic [31:0] tgt,
                          input int hold, input int poke);
    obs_timeout = 1'b0; obs_found = 'x; obs_nonce = 'x; obs_h0 = 'x; obs_h7 = 'x; obs_tried = 'x;
    launches.delete(); msg_bad = 0; dbl_cnt = 0; done_cnt = 0; early_starts = 0;
    model_sweep(base, tgt);
    @(negedge clk);
    for (int i = 0; i < 8; i++) midstate[i] = $urandom;
    for (int i = 0; i < 3; i++) tail[i] = $urandom;
    exp_mid = midstate; exp_tail = tail;
    nonce_base = base; target = tgt; hold_busy = (hold > 0); start = 1'b1;
    @(posedge clk); obs_cycles = 1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (cif.core_start) early_starts++;
      @(posedge clk); obs_cycles++;
      @(negedge clk);
    end
    hold_busy = 1'b0;
    while (busy && obs_cycles < 3000) begin
      if (done) begin
        obs_found = found; obs_nonce = found_nonce; obs_h0 = found_hash[0];
        obs_h7 = found_hash[7]; obs_tried = tried;
      end
      start = (obs_cycles == poke);
      if (start) begin
        for (int i = 0; i < 3; i++) tail[i] = ~tail[i];
        nonce_base = $urandom; target = $urandom;
      end
      @(posedge clk); obs_cycles++;
      @(negedge clk);
    end
    start = 1'b0;
    if (busy) obs_timeout = 1'b1;
  endtask

  // Compares every observed result of the last sweep against the model.
  task automatic test_sweep_result(input string tag, input logic chk_cycles);
    logic [31:0] eh7;
    int seq_bad;
    eh7 = exp_found ? exp_nonce : 32'h0;
    seq_bad = 0;
    for (int i = 0; i < launches.size(); i++)
      if (launches[i] !== nonce_base_of_sweep + 32'(i)) seq_bad++;
    total++; if (obs_timeout !== 1'b0) begin bad++; $display("FAIL %s timeout: got %0b want 0", tag, obs_timeout); end
    total++; if (obs_found !== exp_found) begin bad++; $display("FAIL %s found: got %0h want %0h", tag, obs_found, exp_found); end
    total++; if (obs_nonce !== (exp_found ? exp_nonce : 32'h0)) begin bad++; $display("FAIL %s found_nonce: got %h want %h", tag, obs_nonce, exp_nonce); end
    total++; if (obs_h0 !== (exp_found ? exp_h0 : 32'h0)) begin bad++; $display("FAIL %s found_hash0: got %h want %h", tag, obs_h0, exp_h0); end
    total++; if (obs_h7 !== eh7) begin bad++; $display("FAIL %s found_hash7: got %h want %h", tag, obs_h7, eh7); end
    total++; if (obs_tried !== 16'(exp_tried)) begin bad++; $display("FAIL %s tried: got %0d want %0d", tag, obs_tried, exp_tried); end
    total++; if (launches.size() != exp_tried) begin bad++; $display("FAIL %s launches: got %0d want %0d", tag, launches.size(), exp_tried); end
    total++; if (seq_bad != 0) begin bad++; $display("FAIL %s nonce_seq: got %0d wrong want 0", tag, seq_bad); end
    total++; if (msg_bad != 0) begin bad++; $display("FAIL %s msg_inh: got %0d wrong want 0", tag, msg_bad); end
    total++; if (dbl_cnt != 0) begin bad++; $display("FAIL %s core_start_width: got %0d long want 0", tag, dbl_cnt); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_cnt); end
    if (chk_cycles) begin
      total++; if (obs_cycles != exp_tried * (4 + L) + 2) begin bad++; $display("FAIL %s cycles: got %0d want %0d", tag, obs_cycles, exp_tried * (4 + L) + 2); end
    end
  endtask

  logic [31:0] nonce_base_of_sweep;

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 8; i++) midstate[i] = $urandom;
    for (int i = 0; i < 3; i++) tail[i] = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %0b want 0", done); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL reset_found: got %0b want 0", found); end
    total++; if (tried !== 16'd0) begin bad++; $display("FAIL reset_tried: got %0d want 0", tried); end
    total++; if (found_nonce !== 32'd0) begin bad++; $display("FAIL reset_found_nonce: got %h want 0", found_nonce); end
    total++; if (cif.core_start !== 1'b0) begin bad++; $display("FAIL reset_core_start: got %0b want 0", cif.core_start); end
    total++; if (cif.core_inh[0] !== 32'd0) begin bad++; $display("FAIL reset_core_inh: got %h want 0", cif.core_inh[0]); end
    total++; if (cif.core_message[0] !== 32'd0) begin bad++; $display("FAIL reset_core_msg: got %h want 0", cif.core_message[0]); end
    reset_n = 1'b1;
  endtask

  task automatic test_no_hit();
    nonce_base_of_sweep = 32'h0;
    do_sweep(32'h0, 32'h1, 0, -1);
    test_sweep_result("no_hit", 1'b1);
  endtask

  task automatic test_single_hit();
    nonce_base_of_sweep = 32'hFFFF0000;
    do_sweep(32'hFFFF0000, 32'd8, 0, -1);
    test_sweep_result("single_hit", 1'b1);
    total++; if (obs_nonce !== 32'hFFFF0000) begin bad++; $display("FAIL single_hit_nonce_abs: got %h want ffff0000", obs_nonce); end
  endtask

  task automatic test_wrap();
    logic [31:0] want [4];
    want = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    nonce_base_of_sweep = 32'hFFFFFFFE;
    do_sweep(32'hFFFFFFFE, 32'h0, 0, -1);
    test_sweep_result("wrap", 1'b1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (launches.size() <= i || launches[i] !== want[i]) begin
        bad++; $display("FAIL wrap_msg%0d: got %h want %h", i, (launches.size() > i) ? launches[i] : 32'hx, want[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] b, t;
    for (int k = 0; k < 8; k++) begin
      b = ($urandom_range(0, 3) != 0) ? 32'hFFFF0000 + 32'($urandom_range(0, 40)) : $urandom;
      t = ($urandom_range(0, 4) != 0) ? 32'($urandom_range(0, 50)) : $urandom;
      nonce_base_of_sweep = b;
      do_sweep(b, t, 0, -1);
      test_sweep_result($sformatf("random%0d", k), 1'b1);
    end
  endtask

  task automatic test_busy_core();
    nonce_base_of_sweep = 32'hFFFF0005;
    do_sweep(32'hFFFF0005, 32'd12, 20, -1);
    total++; if (early_starts != 0) begin bad++; $display("FAIL busy_core_early_start: got %0d want 0", early_starts); end
    test_sweep_result("busy_core", 1'b0);
  endtask

  task automatic test_start_during_sweep();
    nonce_base_of_sweep = 32'hFFFF0010;
    do_sweep(32'hFFFF0010, 32'd20, 0, 40);
    test_sweep_result("start_mid", 1'b0);
    repeat (5) @(negedge clk);
    total++; if (done_cnt != 1 || busy !== 1'b0) begin bad++; $display("FAIL start_mid_after: got done=%0d busy=%0b want 1/0", done_cnt, busy); end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    @(negedge clk);
    nonce_base = 32'h0; target = 32'h1; exp_tail = tail; exp_mid = midstate; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (tried < 16'd2 && n < 200) begin @(negedge clk); n++; end
    total++; if (tried < 16'd2) begin bad++; $display("FAIL reset_mid_progress: got tried=%0d want >=2", tried); end
    n = 0;
    while (!cif.core_start && n < 100) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_mid_busy: got %0b want 0", busy); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL reset_mid_found: got %0b want 0", found); end
    total++; if (tried !== 16'd0) begin bad++; $display("FAIL reset_mid_tried: got %0d want 0", tried); end
    total++; if (cif.core_start !== 1'b0) begin bad++; $display("FAIL reset_mid_core_start: got %0b want 0", cif.core_start); end
    reset_n = 1'b1;
    nonce_base_of_sweep = 32'hFFFF0003;
    do_sweep(32'hFFFF0003, 32'd5, 0, -1);
    test_sweep_result("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_no_hit();
    test_single_hit();
    test_wrap();
    test_random();
    test_busy_core();
    test_start_during_sweep();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
